// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP32 add/sub sequencer.
package fpu_pkg;

  // Sequencer states; the datapath is walked in this order on the normal path.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } seq_state_t;

  // Canonical quiet NaN returned for every invalid or NaN-input operation.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // IEEE-754 single-precision field view.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  function automatic logic is_nan(input fp32_t f);
    return (f.exp == 8'hFF) && (f.mant != 23'd0);
  endfunction

  function automatic logic is_inf(input fp32_t f);
    return (f.exp == 8'hFF) && (f.mant == 23'd0);
  endfunction

  function automatic logic is_zero(input fp32_t f);
    return (f.exp == 8'h00) && (f.mant == 23'd0);
  endfunction

endpackage

// File: rtl/unit_exception_signal.sv
// Operand classifier for add/sub. Flags the infinity/zero combinations
// whose result is known without running the datapath:
//   o_spe_m   : Inf op Inf with opposite effective signs (invalid -> NaN)
//   o_spe_sig : Inf op Inf same effective sign, Inf op 0, or 0 op Inf
// NaN operands are not covered here; is_inf excludes them by construction.
module unit_exception_signal
  import fpu_pkg::*;
(
  input  logic [31:0] i_opA,
  input  logic [31:0] i_opB,
  input  logic        i_aos,
  output logic        o_spe_sig,
  output logic        o_spe_m
);

  fp32_t w_a;
  fp32_t w_b;
  logic  w_eff_b;
  logic  w_both_inf;

  assign w_a        = fp32_t'(i_opA);
  assign w_b        = fp32_t'(i_opB);
  // Subtraction is addition of B with its sign flipped.
  assign w_eff_b    = w_b.sign ^ ~i_aos;
  assign w_both_inf = is_inf(w_a) && is_inf(w_b);

  assign o_spe_m   = w_both_inf && (w_a.sign != w_eff_b);
  assign o_spe_sig = (w_both_inf && (w_a.sign == w_eff_b))
                   || (is_inf(w_a) && is_zero(w_b))
                   || (is_zero(w_a) && is_inf(w_b));

endmodule

// File: rtl/fpu_addsub_sequencer.sv
// Multi-cycle controller for the FP32 add/sub datapath. Accepts one op per
// handshake, bypasses special operand combinations, otherwise strobes the
// datapath through align -> add -> normalise (bounded) -> round, and holds
// the result until the consumer takes it.
module fpu_addsub_sequencer
  import fpu_pkg::*;
#(
  parameter int NORM_MAX = 24,
  parameter int CNT_W    = $clog2(NORM_MAX + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_aos,
  input  logic [31:0] i_opA,
  input  logic [31:0] i_opB,
  output logic        o_dp_load,
  output logic        o_dp_align_en,
  output logic        o_dp_add_en,
  output logic        o_dp_norm_en,
  input  logic        i_dp_norm_done,
  output logic        o_dp_round_en,
  input  logic [31:0] i_dp_result,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_flag_nan,
  output logic        o_flag_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NORM_MAX - 1);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic             r_aos;
  fp32_t            r_opA;
  fp32_t            r_opB;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_result;
  logic             r_flag_nan;
  logic             r_flag_err;

  logic             w_spe_sig;
  logic             w_spe_m;
  logic             w_nan_in;
  logic             w_special;
  logic             w_eff_b;
  logic             w_timeout;
  logic [31:0]      w_bypass;
  logic             w_bypass_nan;
  logic             w_abort;

  assign o_result   = r_result;
  assign o_flag_nan = r_flag_nan;
  assign o_flag_err = r_flag_err;

  // Flush only matters while an op is in flight.
  assign w_abort   = i_flush && (r_state != S_IDLE);
  assign w_eff_b   = r_opB.sign ^ ~r_aos;
  assign w_nan_in  = is_nan(r_opA) || is_nan(r_opB);
  assign w_special = w_nan_in || w_spe_m || w_spe_sig;

  unit_exception_signal u_exc (
    .i_opA     (r_opA),
    .i_opB     (r_opB),
    .i_aos     (r_aos),
    .o_spe_sig (w_spe_sig),
    .o_spe_m   (w_spe_m)
  );

  // Bypass result for special operand combinations; NaN takes priority.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_bypass     = QNAN;
    w_bypass_nan = 1'b1;
    if (!(w_nan_in || w_spe_m)) begin
      w_bypass_nan = 1'b0;
      if (is_inf(r_opA)) w_bypass = r_opA;
      else               w_bypass = {w_eff_b, 8'hFF, 23'd0};
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_next        = r_state;
    o_ready       = 1'b0;
    o_valid       = 1'b0;
    o_dp_load     = 1'b0;
    o_dp_align_en = 1'b0;
    o_dp_add_en   = 1'b0;
    o_dp_norm_en  = 1'b0;
    o_dp_round_en = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          o_dp_load = 1'b1;
          w_next    = S_CLASS;
        end
      end
      S_CLASS: w_next = w_special ? S_DONE : S_ALIGN;
      S_ALIGN: begin
        o_dp_align_en = 1'b1;
        w_next        = S_ADD;
      end
      S_ADD: begin
        o_dp_add_en = 1'b1;
        w_next      = S_NORM;
      end
      S_NORM: begin
        o_dp_norm_en = 1'b1;
        // Done on the last allowed iteration still counts as done.
        if (i_dp_norm_done) begin
          w_next = S_ROUND;
        end else if (r_cnt == CNT_LAST) begin
          w_next    = S_ROUND;
          w_timeout = 1'b1;
        end
      end
      S_ROUND: begin
        o_dp_round_en = 1'b1;
        w_next        = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next        = S_IDLE;
      o_dp_align_en = 1'b0;
      o_dp_add_en   = 1'b0;
      o_dp_norm_en  = 1'b0;
      o_dp_round_en = 1'b0;
      w_timeout     = 1'b0;
    end
  end

  // Operand latch on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aos <= 1'b0;
      r_opA <= '0;
      r_opB <= '0;
    end else if (r_state == S_IDLE && i_valid) begin
      r_aos <= i_aos;
      r_opA <= fp32_t'(i_opA);
      r_opB <= fp32_t'(i_opB);
    end
  end

  // Normalise iteration counter: counts NORM cycles, zero elsewhere.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_cnt <= '0;
    else if (w_abort || r_state != S_NORM) r_cnt <= '0;
    else                                   r_cnt <= r_cnt + CNT_W'(1);
  end

  // Result and flag registers, held stable through DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result   <= '0;
      r_flag_nan <= 1'b0;
      r_flag_err <= 1'b0;
    end else if (w_abort) begin
      r_flag_nan <= 1'b0;
      r_flag_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_valid) begin
          r_flag_nan <= 1'b0;
          r_flag_err <= 1'b0;
        end
        S_CLASS: if (w_special) begin
          r_result   <= w_bypass;
          r_flag_nan <= w_bypass_nan;
        end
        S_NORM:  if (w_timeout) r_flag_err <= 1'b1;
        S_ROUND: r_result <= i_dp_result;
        S_DONE: if (i_ready) begin
          r_flag_nan <= 1'b0;
          r_flag_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Self-checking bench for fpu_addsub_sequencer: a behavioural model predicts
// result, flags, latency and strobe counts per operation; a negedge monitor
// compares every in-flight cycle; a responder plays the datapath and consumer.
module tb_fpu_addsub_sequencer;

  localparam int          NORM_MAX = 24;
  localparam logic [31:0] QNAN_C   = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] res;
    bit          nan;
    bit          err;
    int          lat;
    int          n;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_aos = 1'b0;
  logic [31:0] i_opA = '0;
  logic [31:0] i_opB = '0;
  logic        o_dp_load;
  logic        o_dp_align_en;
  logic        o_dp_add_en;
  logic        o_dp_norm_en;
  logic        i_dp_norm_done = 1'b0;
  logic        o_dp_round_en;
  logic [31:0] i_dp_result = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_flag_nan;
  logic        o_flag_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  exp_t cur;
  int   cur_done_at = 1;
  int   cur_rd      = 0;
  int   ops_done    = 0;

  fpu_addsub_sequencer #(.NORM_MAX(NORM_MAX)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_aos          (i_aos),
    .i_opA          (i_opA),
    .i_opB          (i_opB),
    .o_dp_load      (o_dp_load),
    .o_dp_align_en  (o_dp_align_en),
    .o_dp_add_en    (o_dp_add_en),
    .o_dp_norm_en   (o_dp_norm_en),
    .i_dp_norm_done (i_dp_norm_done),
    .o_dp_round_en  (o_dp_round_en),
    .i_dp_result    (i_dp_result),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .o_flag_nan     (o_flag_nan),
    .o_flag_err     (o_flag_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what an add/sub op must produce, from the operand rules alone.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic aos,
                                 input logic [31:0] dp, input int done_at);
    exp_t e;
    logic eb;
    bit an, bn, ai, bi, az, bz;
    eb = b[31] ^ ~aos;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:0] == 0);
    bz = (b[30:0] == 0);
    e.nan = 0; e.err = 0; e.lat = 2; e.n = 0; e.res = '0;
    if (an || bn) begin
      e.res = QNAN_C; e.nan = 1;
    end else if (ai && bi) begin
      if (a[31] == eb) e.res = a;
      else begin e.res = QNAN_C; e.nan = 1; end
    end else if (ai && bz) begin
      e.res = a;
    end else if (az && bi) begin
      e.res = {eb, 8'hFF, 23'd0};
    end else begin
      e.res = dp;
      e.n   = (done_at <= NORM_MAX) ? done_at : NORM_MAX;
      e.err = (done_at > NORM_MAX);
      e.lat = 5 + e.n;
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0, 1:    return {s, 8'hFF, 23'd0};
      2:       return {s, 31'd0};
      3:       return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Datapath and consumer stand-in, driven just after each rising edge.
  int nc = 0;
  int vc = 0;
  always @(posedge i_clk) begin
    #1;
    if (o_dp_norm_en) begin
      nc++;
      i_dp_norm_done = (nc == cur_done_at);
    end else begin
      nc = 0;
      i_dp_norm_done = 1'b0;
    end
    if (o_valid) begin
      vc++;
      i_ready = (vc > cur_rd);
    end else begin
      vc = 0;
      i_ready = 1'b0;
    end
  end

  // Compare process: follows each op from accept to hand-off at negedge.
  bit in_flight = 0;
  bit seen_valid = 0;
  int lat = 0;
  int c_align = 0, c_add = 0, c_norm = 0, c_round = 0;
  always @(negedge i_clk) begin
    if (!mon_en) begin
      in_flight = 0;
    end else if (!in_flight) begin
      check("idle_ready", o_ready, 1);
      check("idle_valid", o_valid, 0);
      check("idle_strobes", {o_dp_align_en, o_dp_add_en, o_dp_norm_en, o_dp_round_en}, 0);
      if (o_ready && i_valid) begin
        check("accept_load", o_dp_load, 1);
        in_flight = 1; seen_valid = 0; lat = 0;
        c_align = 0; c_add = 0; c_norm = 0; c_round = 0;
      end
    end else begin
      if (!seen_valid) begin
        lat++;
        check("busy_ready", o_ready, 0);
        check("busy_load", o_dp_load, 0);
        if (o_dp_align_en) begin c_align++; check("align_pos", lat, 2); end
        if (o_dp_add_en)   begin c_add++;   check("add_pos", lat, 3); end
        if (o_dp_norm_en)  c_norm++;
        if (o_dp_round_en) begin c_round++; check("round_pos", lat, 4 + cur.n); end
        if (o_valid) begin
          seen_valid = 1;
          check("latency", lat, cur.lat);
          check("n_align", c_align, (cur.lat == 2) ? 0 : 1);
          check("n_add", c_add, (cur.lat == 2) ? 0 : 1);
          check("n_norm", c_norm, cur.n);
          check("n_round", c_round, (cur.lat == 2) ? 0 : 1);
        end else if (lat > 100) begin
          check("valid_timeout", lat, cur.lat);
          in_flight = 0;
        end
      end
      if (seen_valid) begin
        check("done_valid", o_valid, 1);
        check("done_ready", o_ready, 0);
        check("result", o_result, cur.res);
        check("flag_nan", o_flag_nan, cur.nan);
        check("flag_err", o_flag_err, cur.err);
        check("done_strobes", {o_dp_align_en, o_dp_add_en, o_dp_norm_en, o_dp_round_en}, 0);
        if (i_ready) begin
          in_flight = 0;
          ops_done++;
        end
      end
    end
  end

  // Issue one op and wait (bounded) for its hand-off. Call just after a posedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic aos,
                        input logic [31:0] dp, input int done_at, input int rd);
    int start;
    int k;
    cur         = model(a, b, aos, dp, done_at);
    cur_done_at = done_at;
    cur_rd      = rd;
    i_dp_result = dp;
    i_opA = a; i_opB = b; i_aos = aos; i_valid = 1'b1;
    start = ops_done;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_opA = $urandom; i_opB = $urandom; i_aos = 1'($urandom_range(0, 1));
    k = 0;
    while (ops_done == start && k < 200) begin
      @(posedge i_clk);
      k++;
    end
    if (ops_done == start) check("op_timeout", k, 0);
    #1;
    repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
  endtask

  exp_t pin;

  initial begin
    // Reset
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_strobes", {o_dp_load, o_dp_align_en, o_dp_add_en, o_dp_norm_en, o_dp_round_en}, 0);
    check("rst_result", o_result, 0);
    check("rst_flags", {o_flag_nan, o_flag_err}, 0);
    @(posedge i_clk); #1;
    mon_en = 1'b1;

    // Hand-computed pins on the model itself
    pin = model(32'h7F800000, 32'hFF800000, 1'b1, 32'h0, 1);
    check("pin_infinf_res", pin.res, 32'h7FC00000);
    check("pin_infinf_lat", pin.lat, 2);
    pin = model(32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 1);
    check("pin_norm_res", pin.res, 32'h40400000);
    check("pin_norm_lat", pin.lat, 6);
    pin = model(32'h00000000, 32'h7F800000, 1'b0, 32'h0, 1);
    check("pin_zero_sub_inf", pin.res, 32'hFF800000);
    pin = model(32'h3F800000, 32'h3F800000, 1'b1, 32'h0, 100);
    check("pin_timeout_lat", pin.lat, 5 + NORM_MAX);

    // Directed cases
    run_op(32'h7F800000, 32'hFF800000, 1'b1, 32'h12345678, 1, 0);  // Inf + -Inf -> NaN
    run_op(32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 1, 5);  // 1+2, backpressure
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 100, 0); // timeout
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, NORM_MAX, 0); // done on last
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, NORM_MAX + 1, 1);
    run_op(32'hFF800000, 32'h00000000, 1'b1, 32'h0, 1, 0);  // -Inf + 0
    run_op(32'h80000000, 32'h7F800000, 1'b0, 32'h0, 1, 0);  // -0 - Inf
    run_op(32'h7F800000, 32'h7F800000, 1'b0, 32'h0, 1, 0);  // Inf - Inf -> NaN
    run_op(32'h7F800000, 32'hFF800000, 1'b0, 32'h0, 1, 2);  // Inf - -Inf -> Inf
    run_op(32'h7FC00001, 32'h3F800000, 1'b1, 32'h0, 1, 0);  // NaN in
    run_op(32'h40000000, 32'h7F800000, 1'b1, 32'hABCD0123, 3, 0); // finite + Inf: datapath

    // Randomised ops
    for (int i = 0; i < 60; i++)
      run_op(pick(), pick(), 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(1, NORM_MAX + 3), $urandom_range(0, 3));

    // Flush in ADD
    mon_en = 1'b0;
    cur_done_at = 100;
    i_opA = 32'h3F800000; i_opB = 32'h40000000; i_aos = 1'b1; i_valid = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1 i_flush = 1'b1;
    @(negedge i_clk);
    check("flush_add_strobe", o_dp_add_en, 0);
    @(posedge i_clk); #1 i_flush = 1'b0;
    check("flush_idle", o_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      check("flush_no_valid", o_valid, 0);
      check("flush_no_strobe", {o_dp_align_en, o_dp_add_en, o_dp_norm_en, o_dp_round_en}, 0);
    end

    // Reset mid-operation
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0;
    repeat (6) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("midrst_ready", o_ready, 1);
    check("midrst_valid", o_valid, 0);
    check("midrst_norm", o_dp_norm_en, 0);
    check("midrst_result", o_result, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    mon_en = 1'b1;
    run_op(32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
